// File: rtl/mips_pkg.sv
// +-------------------------------------------------------------------------+
// | mips_pkg : datapath widths, ALU op classes and control-bundle layout    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  // Control bundle layout shared by ID/EX, EX/MEM and MEM/WB; alu_op sits in the low bits.
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_REG_DST    = ALU_OP_W;
  localparam int CTRL_ALU_SRC    = ALU_OP_W + 1;
  localparam int CTRL_BRANCH     = ALU_OP_W + 2;
  localparam int CTRL_MEM_WRITE  = ALU_OP_W + 3;
  localparam int CTRL_MEM_READ   = ALU_OP_W + 4;
  localparam int CTRL_MEM_TO_REG = ALU_OP_W + 5;
  localparam int CTRL_REG_WRITE  = ALU_OP_W + 6;
  localparam int CTRL_W          = ALU_OP_W + 7;

endpackage

`default_nettype wire

// File: rtl/pipe_field_reg.sv
// +-------------------------------------------------------------------------+
// | pipe_field_reg : W-bit pipeline field with sync reset, clear and enable |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Clear beats enable so a flush lands a bubble even while stalled.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/id_ex_pipeline_reg.sv
// +-------------------------------------------------------------------------+
// | id_ex_pipeline_reg : ID/EX register with stall, flush, bubble counter   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module id_ex_pipeline_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rd_data1,
  input  logic [DATA_W-1:0]     id_rd_data2,
  input  logic [DATA_W-1:0]     id_imm_ext,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rd_data1,
  output logic [DATA_W-1:0]     ex_rd_data2,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [CNT_W-1:0]      bubble_count
);

  import mips_pkg::*;

  localparam int DATA_GRP_W = 4 * DATA_W;
  localparam int SPEC_GRP_W = 3 * REG_ADDR_W;
  localparam int CTRL_GRP_W = CTRL_W + 1;

  logic                  w_load;
  logic [CTRL_W-1:0]     w_ctrl_in;
  logic [CTRL_W-1:0]     w_ctrl_out;
  logic [DATA_GRP_W-1:0] w_data_out;
  logic [SPEC_GRP_W-1:0] w_spec_out;
  logic [CNT_W-1:0]      bubble_count_d;
  logic [CNT_W-1:0]      bubble_count_q;

  assign w_load = ~stall;

  // An invalid decode slot still carries data, but must never cause side effects in EX.
  always_comb begin
    w_ctrl_in                                  = '0;
    w_ctrl_in[CTRL_REG_WRITE]                  = id_reg_write;
    w_ctrl_in[CTRL_MEM_TO_REG]                 = id_mem_to_reg;
    w_ctrl_in[CTRL_MEM_READ]                   = id_mem_read;
    w_ctrl_in[CTRL_MEM_WRITE]                  = id_mem_write;
    w_ctrl_in[CTRL_BRANCH]                     = id_branch;
    w_ctrl_in[CTRL_ALU_SRC]                    = id_alu_src;
    w_ctrl_in[CTRL_REG_DST]                    = id_reg_dst;
    w_ctrl_in[CTRL_ALU_OP_LSB +: ALU_OP_W]     = id_alu_op;
    if (!id_valid) begin
      w_ctrl_in = '0;
    end
  end

  pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (w_load),
    .d     ({id_pc_plus4, id_rd_data1, id_rd_data2, id_imm_ext}),
    .q     (w_data_out)
  );

  pipe_field_reg #(.W(SPEC_GRP_W)) u_spec_reg (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (w_load),
    .d     ({id_rs, id_rt, id_rd}),
    .q     (w_spec_out)
  );

  pipe_field_reg #(.W(CTRL_GRP_W)) u_ctrl_reg (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (w_load),
    .d     ({id_valid, w_ctrl_in}),
    .q     ({ex_valid, w_ctrl_out})
  );

  assign {ex_pc_plus4, ex_rd_data1, ex_rd_data2, ex_imm_ext} = w_data_out;
  assign {ex_rs, ex_rt, ex_rd}                               = w_spec_out;

  assign ex_reg_write  = w_ctrl_out[CTRL_REG_WRITE];
  assign ex_mem_to_reg = w_ctrl_out[CTRL_MEM_TO_REG];
  assign ex_mem_read   = w_ctrl_out[CTRL_MEM_READ];
  assign ex_mem_write  = w_ctrl_out[CTRL_MEM_WRITE];
  assign ex_branch     = w_ctrl_out[CTRL_BRANCH];
  assign ex_alu_src    = w_ctrl_out[CTRL_ALU_SRC];
  assign ex_reg_dst    = w_ctrl_out[CTRL_REG_DST];
  assign ex_alu_op     = w_ctrl_out[CTRL_ALU_OP_LSB +: ALU_OP_W];

  // Saturating count of flushed edges; a stalled flush still counts.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (flush && (bubble_count_q != {CNT_W{1'b1}})) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;

endmodule

`default_nettype wire
